mux_nin_rr_reg: RTL and testbench

//   Parametrised N-input, WIDTH-bit selector with a registered output stage and

---
 rtl/mux_nin_rr_reg.sv | 104 ++++++++++
 tb/tb_mux_nin_rr_reg.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mux_nin_rr_reg.sv
// N-input registered selector: fixed channel select (mode 0) or round-robin (mode 1).
// One-cycle latency; the single output slot can drain and refill in the same cycle.
module mux_nin_rr_reg #(
  parameter int WIDTH  = 16,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_src,
  output logic                    out_valid,
  input  logic                    out_ready
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slot_t;

  slot_t            r_state;
  slot_t            w_state_nxt;
  logic [WIDTH-1:0] r_out_data;
  logic [SEL_W-1:0] r_out_src;
  logic [SEL_W-1:0] r_rr_ptr;

  logic             w_can_load;
  logic             w_grant;
  logic [SEL_W-1:0] w_gidx;
  logic [SEL_W-1:0] w_ptr_nxt;
  logic [WIDTH-1:0] w_gdat;
  int               w_dist;
  int               w_best;

  // Grant selection; in round-robin mode the valid channel closest to r_rr_ptr wins.
  always_comb begin
    w_can_load = (r_state == EMPTY) || out_ready;
    w_grant    = 1'b0;
    w_gidx     = '0;
    w_dist     = 0;
    w_best     = NUM_IN;
    if (!mode) begin
      for (int i = 0; i < NUM_IN; i++) begin
        if (sel == SEL_W'(i)) begin
          w_gidx  = SEL_W'(i);
          w_grant = in_valid[i];
        end
      end
    end else begin
      for (int i = 0; i < NUM_IN; i++) begin
        if (i >= int'(r_rr_ptr)) w_dist = i - int'(r_rr_ptr);
        else                     w_dist = i + NUM_IN - int'(r_rr_ptr);
        if (in_valid[i] && (w_dist < w_best)) begin
          w_best  = w_dist;
          w_gidx  = SEL_W'(i);
          w_grant = 1'b1;
        end
      end
    end
    w_grant = w_grant && w_can_load;
  end

  always_comb begin
    w_gdat   = '0;
    in_ready = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (w_gidx == SEL_W'(i)) begin
        w_gdat      = in_data[i*WIDTH +: WIDTH];
        in_ready[i] = w_grant && !rst;
      end
    end
  end

  assign w_ptr_nxt = (int'(w_gidx) == NUM_IN - 1) ? '0 : w_gidx + SEL_W'(1);

  always_comb begin
    w_state_nxt = r_state;
    if (w_grant)        w_state_nxt = FULL;
    else if (out_ready) w_state_nxt = EMPTY;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= EMPTY;
      r_out_data <= '0;
      r_out_src  <= '0;
      r_rr_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) begin
        r_out_data <= w_gdat;
        r_out_src  <= w_gidx;
        if (mode) r_rr_ptr <= w_ptr_nxt;
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_src   = r_out_src;
  assign out_valid = (r_state == FULL);

endmodule

// File: tb/tb_mux_nin_rr_reg.sv
// Directed bench for mux_nin_rr_reg using three configurations (2-, 4- and 3-input).
module tb_mux_nin_rr_reg;

  logic clk;
  logic rst;

  logic       a_mode, a_sel, a_out_valid, a_out_ready, a_out_src;
  logic [7:0] a_in_data;
  logic [1:0] a_in_valid, a_in_ready;
  logic [3:0] a_out_data;

  logic        b_mode, b_out_valid, b_out_ready;
  logic [1:0]  b_sel, b_out_src;
  logic [63:0] b_in_data;
  logic [3:0]  b_in_valid, b_in_ready;
  logic [15:0] b_out_data;

  logic        c_mode, c_out_valid, c_out_ready;
  logic [1:0]  c_sel, c_out_src;
  logic [47:0] c_in_data;
  logic [2:0]  c_in_valid, c_in_ready;
  logic [15:0] c_out_data;

  int n_chk  = 0;
  int n_pass = 0;

  mux_nin_rr_reg #(.WIDTH(4), .NUM_IN(2), .SEL_W(1)) dut_a (
    .clk(clk), .rst(rst), .mode(a_mode), .sel(a_sel), .in_data(a_in_data),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .out_data(a_out_data),
    .out_src(a_out_src), .out_valid(a_out_valid), .out_ready(a_out_ready)
  );

  mux_nin_rr_reg #(.WIDTH(16), .NUM_IN(4), .SEL_W(2)) dut_b (
    .clk(clk), .rst(rst), .mode(b_mode), .sel(b_sel), .in_data(b_in_data),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .out_data(b_out_data),
    .out_src(b_out_src), .out_valid(b_out_valid), .out_ready(b_out_ready)
  );

  mux_nin_rr_reg #(.WIDTH(16), .NUM_IN(3), .SEL_W(2)) dut_c (
    .clk(clk), .rst(rst), .mode(c_mode), .sel(c_sel), .in_data(c_in_data),
    .in_valid(c_in_valid), .in_ready(c_in_ready), .out_data(c_out_data),
    .out_src(c_out_src), .out_valid(c_out_valid), .out_ready(c_out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_rr[6];
    int exp_sp[4];
    exp_rr = '{0, 1, 2, 3, 0, 1};
    exp_sp = '{3, 1, 3, 1};

    rst = 1'b1;
    a_mode = 1'b0; a_sel = 1'b0; a_in_data = '0; a_in_valid = '0; a_out_ready = 1'b0;
    b_mode = 1'b1; b_sel = '0;   b_in_data = '0; b_in_valid = 4'hF; b_out_ready = 1'b1;
    c_mode = 1'b0; c_sel = '0;   c_in_data = '0; c_in_valid = '0; c_out_ready = 1'b0;

    // Reset state, with requests pending on b to show in_ready is gated by rst.
    step();
    chk("rst_b_valid", b_out_valid, 0);
    chk("rst_b_data", b_out_data, 0);
    chk("rst_b_src", b_out_src, 0);
    chk("rst_b_ready", b_in_ready, 0);
    chk("rst_a_valid", a_out_valid, 0);
    chk("rst_c_valid", c_out_valid, 0);
    b_in_valid = '0;
    b_mode = 1'b0;
    rst = 1'b0;
    step();

    // Mode 0 sweep on the 2-input, 4-bit instance.
    a_mode = 1'b0; a_in_valid = 2'b11; a_out_ready = 1'b1;
    for (int s = 0; s < 2; s++) begin
      for (int j = 0; j < 8; j++) begin
        a_sel = 1'(s);
        a_in_data = {4'(14 - 2*j), 4'(2*j)};
        #1;
        chk("m0_ready", a_in_ready, (s == 1) ? 2 : 1);
        step();
        chk("m0_data", a_out_data, (s == 1) ? 14 - 2*j : 2*j);
        chk("m0_src", a_out_src, s);
        chk("m0_valid", a_out_valid, 1);
      end
    end
    a_in_valid = '0;
    step();
    chk("m0_drain", a_out_valid, 0);

    // Backpressure on the 4-input instance.
    b_mode = 1'b0; b_sel = 2'd0; b_in_data = {48'h0, 16'h1234}; b_in_valid = 4'b0001;
    b_out_ready = 1'b1;
    step();
    chk("bp_load_data", b_out_data, 32'h1234);
    chk("bp_load_valid", b_out_valid, 1);
    b_out_ready = 1'b0;
    b_in_data = {48'h0, 16'h5678};
    #1;
    chk("bp_ready0", b_in_ready, 0);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("bp_hold_data", b_out_data, 32'h1234);
      chk("bp_hold_valid", b_out_valid, 1);
      chk("bp_hold_ready", b_in_ready, 0);
    end
    b_out_ready = 1'b1;
    #1;
    chk("bp_release_ready", b_in_ready, 4'b0001);
    step();
    chk("bp_next_data", b_out_data, 32'h5678);
    chk("bp_next_valid", b_out_valid, 1);
    b_in_valid = '0;
    step();
    chk("bp_drain", b_out_valid, 0);

    // Round-robin with every channel valid.
    b_mode = 1'b1; b_in_valid = 4'hF;
    b_in_data = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("rr_ready", b_in_ready, 1 << exp_rr[k]);
      step();
      chk("rr_src", b_out_src, exp_rr[k]);
      chk("rr_data", b_out_data, 32'hA000 + exp_rr[k]);
    end
    b_in_valid = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("rr_ch2_src", b_out_src, 2);
      chk("rr_ch2_valid", b_out_valid, 1);
    end

    // Pointer now at 3; sparse valid on ch1/ch3 wraps through 0.
    b_in_valid = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("sp_ready", b_in_ready, 1 << exp_sp[k]);
      step();
      chk("sp_src", b_out_src, exp_sp[k]);
      chk("sp_data", b_out_data, 32'hA000 + exp_sp[k]);
    end

    // Out-of-range select on the 3-input instance.
    c_mode = 1'b0; c_sel = 2'd3; c_in_valid = 3'b111; c_out_ready = 1'b1;
    c_in_data = {16'hC002, 16'hC001, 16'hC000};
    #1;
    chk("oor_ready", c_in_ready, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("oor_valid", c_out_valid, 0);
    end
    c_sel = 2'd2;
    #1;
    chk("oor_sel2_ready", c_in_ready, 3'b100);
    step();
    chk("oor_sel2_valid", c_out_valid, 1);
    chk("oor_sel2_src", c_out_src, 2);
    chk("oor_sel2_data", c_out_data, 32'hC002);

    // Mid-stream asynchronous reset while b holds a word.
    b_in_valid = 4'hF; b_out_ready = 1'b0;
    step();
    chk("mr_pre_valid", b_out_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("mr_valid", b_out_valid, 0);
    chk("mr_data", b_out_data, 0);
    chk("mr_src", b_out_src, 0);
    chk("mr_ready", b_in_ready, 0);
    #2;
    rst = 1'b0;
    b_out_ready = 1'b1;
    #1;
    chk("mr_ptr_ready", b_in_ready, 4'b0001);
    step();
    chk("mr_ptr_src", b_out_src, 0);
    chk("mr_ptr_valid", b_out_valid, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
